pl_reset_sequencer: RTL and testbench

PL_RESET_SEQUENCER -- requirements
Module: pl_reset_sequencer

---
 rtl/pl_reset_pkg.sv | 24 ++
 rtl/pl_reset_debounce.sv | 29 ++
 rtl/pl_reset_sequencer.sv | 151 +++++++++++++++
 tb/tb_pl_reset_sequencer.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pl_reset_pkg.sv
// Shared types and default constants for the processor-local reset sequencer.
package pl_reset_pkg;

  typedef enum logic [2:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_REL_IC,
    ST_REL_PERIPH,
    ST_RUN
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_EXT = 2'b00,
    CAUSE_AUX = 2'b01,
    CAUSE_SW  = 2'b10,
    CAUSE_DCM = 2'b11
  } cause_t;

  localparam int unsigned DEF_NUM_PERIPH      = 4;
  localparam int unsigned DEF_HOLD_CYCLES     = 16;
  localparam int unsigned DEF_STAGGER_CYCLES  = 2;
  localparam int unsigned DEF_DEBOUNCE_CYCLES = 4;

endpackage

// File: rtl/pl_reset_debounce.sv
// Debounce for an already-synchronous level: asserts after DEBOUNCE_CYCLES
// consecutive high samples, drops on the first low sample.
module pl_reset_debounce
  import pl_reset_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || !din) begin
      cnt  <= '0;
      dout <= 1'b0;
    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
      dout <= 1'b1;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/pl_reset_sequencer.sv
// Reset sequencer: holds all resets after the last source clears, releases the
// interconnect, then staggers peripheral channel releases before RUN.
module pl_reset_sequencer
  import pl_reset_pkg::*;
#(
  parameter int unsigned NUM_PERIPH      = DEF_NUM_PERIPH,
  parameter int unsigned HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int unsigned STAGGER_CYCLES  = DEF_STAGGER_CYCLES,
  parameter int unsigned DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                  slowest_sync_clk,
  input  logic                  ext_reset_in,
  input  logic                  aux_reset_in,
  input  logic                  dcm_locked,
  input  logic                  sw_reset_req,
  output logic                  bus_struct_reset,
  output logic                  interconnect_aresetn,
  output logic [NUM_PERIPH-1:0] peripheral_aresetn,
  output logic [NUM_PERIPH-1:0] peripheral_reset,
  output logic                  reset_done,
  output logic [1:0]            reset_cause
);

  localparam int unsigned HOLD_W = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned STAG_W = $clog2(STAGGER_CYCLES + 1);
  localparam int unsigned IDX_W  = $clog2(NUM_PERIPH + 1);

  state_t                state_q, state_d;
  cause_t                cause_q, cause_d;
  logic [HOLD_W-1:0]     hold_q, hold_d;
  logic [STAG_W-1:0]     stag_q, stag_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  bsr_q, bsr_d;
  logic                  ic_q, ic_d;
  logic [NUM_PERIPH-1:0] per_q, per_d;
  logic [NUM_PERIPH-1:0] prst_q;
  logic                  done_q, done_d;
  logic                  aux_db;
  logic                  src_active;

  pl_reset_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_aux_debounce (
    .clk (slowest_sync_clk),
    .rst (ext_reset_in),
    .din (aux_reset_in),
    .dout(aux_db)
  );

  always_comb begin
    state_d    = state_q;
    cause_d    = cause_q;
    hold_d     = hold_q;
    stag_d     = stag_q;
    idx_d      = idx_q;
    bsr_d      = bsr_q;
    ic_d       = ic_q;
    per_d      = per_q;
    done_d     = done_q;
    // Software requests only count once the system is fully running.
    src_active = !dcm_locked || aux_db || (sw_reset_req && state_q == ST_RUN);

    if (src_active) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      stag_d  = '0;
      idx_d   = '0;
      bsr_d   = 1'b1;
      ic_d    = 1'b0;
      per_d   = '0;
      done_d  = 1'b0;
      if (state_q != ST_ASSERT) begin
        if (!dcm_locked)  cause_d = CAUSE_DCM;
        else if (aux_db)  cause_d = CAUSE_AUX;
        else              cause_d = CAUSE_SW;
      end
    end else begin
      unique case (state_q)
        ST_ASSERT: begin
          state_d = ST_HOLD;
          hold_d  = '0;
        end
        ST_HOLD: begin
          if (hold_q == HOLD_W'(HOLD_CYCLES)) begin
            state_d = ST_REL_IC;
            bsr_d   = 1'b0;
            ic_d    = 1'b1;
            stag_d  = '0;
            idx_d   = '0;
          end else begin
            hold_d = hold_q + HOLD_W'(1);
          end
        end
        // The stagger count starts on the interconnect-release edge, so with a
        // one-cycle stagger the first channel leaves straight out of REL_IC.
        ST_REL_IC, ST_REL_PERIPH: begin
          if (stag_q == STAG_W'(STAGGER_CYCLES - 1)) begin
            stag_d = '0;
            per_d  = per_q | (NUM_PERIPH'(1) << idx_q);
            idx_d  = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_PERIPH - 1)) begin
              state_d = ST_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = ST_REL_PERIPH;
            end
          end else begin
            stag_d  = stag_q + STAG_W'(1);
            state_d = ST_REL_PERIPH;
          end
        end
        ST_RUN: ;
        default: state_d = ST_ASSERT;
      endcase
    end
  end

  always_ff @(posedge slowest_sync_clk) begin
    if (ext_reset_in) begin
      state_q <= ST_ASSERT;
      cause_q <= CAUSE_EXT;
      hold_q  <= '0;
      stag_q  <= '0;
      idx_q   <= '0;
      bsr_q   <= 1'b1;
      ic_q    <= 1'b0;
      per_q   <= '0;
      prst_q  <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      hold_q  <= hold_d;
      stag_q  <= stag_d;
      idx_q   <= idx_d;
      bsr_q   <= bsr_d;
      ic_q    <= ic_d;
      per_q   <= per_d;
      prst_q  <= ~per_d;
      done_q  <= done_d;
    end
  end

  assign bus_struct_reset     = bsr_q;
  assign interconnect_aresetn = ic_q;
  assign peripheral_aresetn   = per_q;
  assign peripheral_reset     = prst_q;
  assign reset_done           = done_q;
  assign reset_cause          = cause_q;

endmodule

// File: tb/tb_pl_reset_sequencer.sv
// Self-checking bench for pl_reset_sequencer: default instance plus a minimal
// NUM_PERIPH=1 / HOLD_CYCLES=2 / STAGGER_CYCLES=1 instance.
module tb_pl_reset_sequencer;

  logic clk;
  logic ext, aux, dcm, sw;
  logic bsr, ic, done;
  logic [3:0] per, prst;
  logic [1:0] cause;

  logic s_ext, s_aux, s_dcm, s_sw;
  logic s_bsr, s_ic, s_done;
  logic [0:0] s_per, s_prst;
  logic [1:0] s_cause;

  logic [12:0] obs, s_obs;
  logic [12:0] sb[$];
  logic [1:0] cur_cause;
  int n_cmp = 0;
  int n_bad = 0;

  pl_reset_sequencer dut (
    .slowest_sync_clk    (clk),
    .ext_reset_in        (ext),
    .aux_reset_in        (aux),
    .dcm_locked          (dcm),
    .sw_reset_req        (sw),
    .bus_struct_reset    (bsr),
    .interconnect_aresetn(ic),
    .peripheral_aresetn  (per),
    .peripheral_reset    (prst),
    .reset_done          (done),
    .reset_cause         (cause)
  );

  pl_reset_sequencer #(
    .NUM_PERIPH     (1),
    .HOLD_CYCLES    (2),
    .STAGGER_CYCLES (1),
    .DEBOUNCE_CYCLES(4)
  ) dut_small (
    .slowest_sync_clk    (clk),
    .ext_reset_in        (s_ext),
    .aux_reset_in        (s_aux),
    .dcm_locked          (s_dcm),
    .sw_reset_req        (s_sw),
    .bus_struct_reset    (s_bsr),
    .interconnect_aresetn(s_ic),
    .peripheral_aresetn  (s_per),
    .peripheral_reset    (s_prst),
    .reset_done          (s_done),
    .reset_cause         (s_cause)
  );

  assign obs   = {bsr, ic, per, prst, done, cause};
  assign s_obs = {s_bsr, s_ic, 3'b000, s_per, 3'b111, s_prst, s_done, s_cause};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outputs e edges after the first all-clear edge (e<0: still asserted).
  function automatic logic [12:0] model(int e, logic [1:0] c, int h, int s, int n);
    logic icr, dn;
    logic [3:0] p;
    icr = (e >= h + 1);
    p = '0;
    for (int k = 0; k < n; k++) if (e >= h + 1 + (k + 1) * s) p[k] = 1'b1;
    dn = (e >= h + 1 + n * s);
    return {~icr, icr, p, ~p, dn, c};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [12:0] ev;
    ext = 1'b1;
    for (int i = 0; i < 7; i++) begin
      sb.push_back(model(-1, 2'b00, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL reset cyc %0d: got %b expected %b", i, obs, ev);
      end
    end
  endtask

  task automatic test_ext_sequence();
    logic [12:0] ev;
    ext = 1'b0;
    for (int e = 0; e < 28; e++) begin
      sb.push_back(model(e, 2'b00, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL ext_seq edge %0d: got %b expected %b", e, obs, ev);
      end
    end
    cur_cause = 2'b00;
  endtask

  task automatic test_aux_short();
    logic [12:0] ev;
    for (int i = 0; i < 8; i++) begin
      aux = (i < 3);
      sb.push_back(model(1000, cur_cause, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL aux_short cyc %0d: got %b expected %b", i, obs, ev);
      end
    end
  endtask

  task automatic test_aux_full();
    logic [12:0] ev;
    for (int i = 0; i < 4; i++) begin
      aux = 1'b1;
      sb.push_back(model(1000, cur_cause, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL aux_debounce cyc %0d: got %b expected %b", i, obs, ev);
      end
    end
    aux = 1'b0;
    for (int e = -1; e < 28; e++) begin
      sb.push_back(model(e, 2'b01, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL aux_seq edge %0d: got %b expected %b", e, obs, ev);
      end
    end
    cur_cause = 2'b01;
  endtask

  task automatic test_sw();
    logic [12:0] ev;
    sw = 1'b1;
    sb.push_back(model(-1, 2'b10, 16, 2, 4));
    tick();
    ev = sb.pop_front();
    n_cmp++;
    if (obs !== ev) begin
      n_bad++;
      $display("FAIL sw_assert: got %b expected %b", obs, ev);
    end
    for (int e = 0; e < 28; e++) begin
      sw = (e == 5 || e == 20);
      sb.push_back(model(e, 2'b10, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL sw_seq edge %0d: got %b expected %b", e, obs, ev);
      end
    end
    sw = 1'b0;
    cur_cause = 2'b10;
  endtask

  task automatic test_dcm_unlock();
    logic [12:0] ev;
    ext = 1'b1;
    sb.push_back(model(-1, 2'b00, 16, 2, 4));
    tick();
    ev = sb.pop_front();
    n_cmp++;
    if (obs !== ev) begin
      n_bad++;
      $display("FAIL ext_pulse: got %b expected %b", obs, ev);
    end
    ext = 1'b0;
    for (int e = 0; e < 24; e++) begin
      dcm = (e < 21) ? 1'b1 : 1'b0;
      sb.push_back((e < 21) ? model(e, 2'b00, 16, 2, 4) : model(-1, 2'b11, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL dcm_drop edge %0d: got %b expected %b", e, obs, ev);
      end
    end
    dcm = 1'b1;
    for (int e = 0; e < 28; e++) begin
      sb.push_back(model(e, 2'b11, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL dcm_relock edge %0d: got %b expected %b", e, obs, ev);
      end
    end
    cur_cause = 2'b11;
  endtask

  task automatic test_dcm_aux_priority();
    logic [12:0] ev;
    for (int i = 0; i < 4; i++) begin
      aux = 1'b1;
      sb.push_back(model(1000, cur_cause, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL prio_pre cyc %0d: got %b expected %b", i, obs, ev);
      end
    end
    aux = 1'b0;
    for (int e = -1; e < 28; e++) begin
      dcm = (e != -1);
      sb.push_back(model(e, 2'b11, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL prio_dcm_aux edge %0d: got %b expected %b", e, obs, ev);
      end
    end
    cur_cause = 2'b11;
  endtask

  task automatic test_ext_aux_coincide();
    logic [12:0] ev;
    for (int i = 0; i < 3; i++) begin
      aux = 1'b1;
      sb.push_back(model(1000, cur_cause, 16, 2, 4));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL coincide_pre cyc %0d: got %b expected %b", i, obs, ev);
      end
    end
    ext = 1'b1;
    for (int e = -1; e < 28; e++) begin
      sb.push_back(model(e, 2'b00, 16, 2, 4));
      tick();
      ext = 1'b0;
      aux = 1'b0;
      ev = sb.pop_front();
      n_cmp++;
      if (obs !== ev) begin
        n_bad++;
        $display("FAIL coincide edge %0d: got %b expected %b", e, obs, ev);
      end
    end
    cur_cause = 2'b00;
  endtask

  task automatic test_small_config();
    logic [12:0] ev;
    s_ext = 1'b1;
    for (int e = -2; e < 8; e++) begin
      if (e == 0) s_ext = 1'b0;
      sb.push_back(model(e, 2'b00, 2, 1, 1));
      tick();
      ev = sb.pop_front();
      n_cmp++;
      if (s_obs !== ev) begin
        n_bad++;
        $display("FAIL small_cfg edge %0d: got %b expected %b", e, s_obs, ev);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    ext = 1'b1; aux = 1'b0; dcm = 1'b1; sw = 1'b0;
    s_ext = 1'b1; s_aux = 1'b0; s_dcm = 1'b1; s_sw = 1'b0;
    cur_cause = 2'b00;
    test_reset();
    test_ext_sequence();
    test_aux_short();
    test_aux_full();
    test_sw();
    test_dcm_unlock();
    test_dcm_aux_priority();
    test_ext_aux_coincide();
    test_small_config();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
